// File: rtl/colour_synth_pipe_if.sv
// ---------------------------------------------------------------------------
// colour_synth_pipe_if
// Bundles the timing-side controls and DAC-side results of colour_synth_pipe.
//   master : the pixel/line timing logic (drives colour, window, burst, FCW)
//   slave  : the colour generator itself
// Signals:
//   colour_num  [5:0]   [5:4] luma, [3:0] hue
//   active_en           active-video window
//   burst_start         1-clk pulse that starts a colour burst
//   fcw_in  [ACC_W-1:0] new frequency word, fcw_load strobes it in
//   fcw_busy            a new frequency word waits for the next wrap
//   phase_wrap          1-clk pulse on accumulator carry-out
//   sc_phase            registered subcarrier phase
//   in_burst            burst state active
//   video   [OUT_W-1:0] DAC sample
//   emph    [2:0]       colour emphasis, present only with COLOUR_EMPHASIS_EN
// ---------------------------------------------------------------------------
interface colour_synth_pipe_if #(
  parameter int ACC_W   = 24,
  parameter int PHASE_W = 8,
  parameter int OUT_W   = 8
);
  logic [5:0]         colour_num;
  logic               active_en;
  logic               burst_start;
  logic [ACC_W-1:0]   fcw_in;
  logic               fcw_load;
  logic               fcw_busy;
  logic               phase_wrap;
  logic [PHASE_W-1:0] sc_phase;
  logic               in_burst;
  logic [OUT_W-1:0]   video;

`ifdef COLOUR_EMPHASIS_EN
  logic [2:0]         emph;

  modport master (
    output colour_num, active_en, burst_start, fcw_in, fcw_load, emph,
    input  fcw_busy, phase_wrap, sc_phase, in_burst, video
  );
  modport slave (
    input  colour_num, active_en, burst_start, fcw_in, fcw_load, emph,
    output fcw_busy, phase_wrap, sc_phase, in_burst, video
  );
`else
  modport master (
    output colour_num, active_en, burst_start, fcw_in, fcw_load,
    input  fcw_busy, phase_wrap, sc_phase, in_burst, video
  );
  modport slave (
    input  colour_num, active_en, burst_start, fcw_in, fcw_load,
    output fcw_busy, phase_wrap, sc_phase, in_burst, video
  );
`endif
endinterface

// File: rtl/colour_synth_pipe.sv
// ---------------------------------------------------------------------------
// colour_synth_pipe
// NES-palette composite colour generator: a phase accumulator (NCO) with a
// glitch-free reloadable frequency word, a BLANK/BURST/ACTIVE mode controller
// and a 3-stage pipeline turning a 6-bit colour code into a DAC sample.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-low reset
//   bus    colour_synth_pipe_if.slave (colour/window/burst/FCW in,
//          busy/wrap/phase/in_burst/video out)
// Optional build macro COLOUR_EMPHASIS_EN: adds bus.emph; in ACTIVE with a
// non-zero emphasis and hue<=13 the level is attenuated by a quarter.
// ---------------------------------------------------------------------------
module colour_synth_pipe #(
  parameter int             ACC_W       = 24,
  parameter int             PHASE_W     = 8,
  parameter int             OUT_W       = 8,
  parameter logic [ACC_W-1:0] FCW_DEFAULT = ACC_W'(1201096),
  parameter int             BURST_CLKS  = 126,
  parameter logic [7:0]     BLANK_LVL   = 8'h3C,
  parameter logic [7:0]     BURST_LO    = 8'h28,
  parameter logic [7:0]     BURST_HI    = 8'h50
) (
  input  logic clk,
  input  logic reset,
  colour_synth_pipe_if.slave bus
);

  typedef enum logic [1:0] {ST_BLANK = 2'd0, ST_BURST = 2'd1, ST_ACTIVE = 2'd2} mode_e;

  localparam int CNT_W = (BURST_CLKS > 1) ? $clog2(BURST_CLKS) : 1;
  localparam logic [OUT_W-1:0] VIDEO_BLANK = OUT_W'(BLANK_LVL) << (OUT_W - 8);

  // 8-bit levels are left-aligned into wider DAC words
  function automatic logic [OUT_W-1:0] align(input logic [7:0] lvl);
    return OUT_W'(lvl) << (OUT_W - 8);
  endfunction

  function automatic logic [7:0] lvl_lo(input logic [1:0] l);
    case (l)
      2'd0:    return 8'h1C;
      2'd1:    return 8'h30;
      2'd2:    return 8'h4C;
      default: return 8'h6A;
    endcase
  endfunction

  function automatic logic [7:0] lvl_hi(input logic [1:0] l);
    case (l)
      2'd0:    return 8'h4C;
      2'd1:    return 8'h6A;
      2'd2:    return 8'h90;
      default: return 8'hA8;
    endcase
  endfunction

  // ---------------- NCO + FCW handshake ----------------
  logic [ACC_W-1:0]   acc_q, acc_d, fcw_act_q, fcw_act_d, fcw_pend_q, fcw_pend_d;
  logic               fcw_busy_q, fcw_busy_d, phase_wrap_q, phase_wrap_d;
  logic [PHASE_W-1:0] sc_phase_q, sc_phase_d;
  logic [ACC_W:0]     acc_sum;
  logic               carry;

  assign acc_sum = {1'b0, acc_q} + {1'b0, fcw_act_q};
  assign carry   = acc_sum[ACC_W];

  always_comb begin
    acc_d        = acc_sum[ACC_W-1:0];
    phase_wrap_d = carry;
    sc_phase_d   = acc_sum[ACC_W-1 -: PHASE_W];
    fcw_act_d    = fcw_act_q;
    fcw_pend_d   = fcw_pend_q;
    fcw_busy_d   = fcw_busy_q;
    // A load coinciding with a wrap takes priority: the swap waits for the
    // next wrap so the freshly loaded word is the one that gets applied.
    if (bus.fcw_load) begin
      fcw_pend_d = bus.fcw_in;
      fcw_busy_d = 1'b1;
    end else if (carry && fcw_busy_q) begin
      fcw_act_d  = fcw_pend_q;
      fcw_busy_d = 1'b0;
    end
  end

  // ---------------- Mode FSM ----------------
  mode_e            state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (bus.burst_start) begin
      state_d     = ST_BURST;
      burst_cnt_d = CNT_W'(BURST_CLKS - 1);
    end else begin
      case (state_q)
        ST_BURST: begin
          if (burst_cnt_q == '0) state_d = bus.active_en ? ST_ACTIVE : ST_BLANK;
          else                   burst_cnt_d = burst_cnt_q - 1'b1;
        end
        default: state_d = bus.active_en ? ST_ACTIVE : ST_BLANK;
      endcase
    end
  end

  // ---------------- Pipeline ----------------
  // S1 takes the next mode so that active_en lines up with colour_num.
  logic [5:0]         s1_colour_q, s1_colour_d;
  mode_e              s1_state_q, s1_state_d, s2_state_q, s2_state_d;
  logic [PHASE_W-1:0] s1_phase_q, s1_phase_d;
  logic               s2_sel_q, s2_sel_d;
  logic [1:0]         s2_luma_q, s2_luma_d;
  logic [3:0]         s2_hue_q, s2_hue_d;
  logic [OUT_W-1:0]   video_q, video_d;
  logic [3:0]         p12, hue_eff;
  logic [4:0]         hue_sum, hue_mod;
  logic [7:0]         lvl;
  logic               atten;
`ifdef COLOUR_EMPHASIS_EN
  logic [2:0]         s1_emph_q, s1_emph_d, s2_emph_q, s2_emph_d;
`endif

  // Phase scaled to twelfths of a subcarrier cycle (0..11)
  assign p12     = 4'(({4'b0, s1_phase_q} * (PHASE_W + 4)'(12)) >> PHASE_W);
  assign hue_eff = (s1_state_q == ST_BURST) ? 4'd8 : s1_colour_q[3:0];
  assign hue_sum = {1'b0, p12} + {1'b0, hue_eff};

  always_comb begin
    s1_colour_d = bus.colour_num;
    s1_state_d  = state_d;
    s1_phase_d  = sc_phase_q;
    if (hue_sum >= 5'd24)      hue_mod = hue_sum - 5'd24;
    else if (hue_sum >= 5'd12) hue_mod = hue_sum - 5'd12;
    else                       hue_mod = hue_sum;
    s2_sel_d   = (hue_mod < 5'd6);
    s2_state_d = s1_state_q;
    s2_luma_d  = s1_colour_q[5:4];
    s2_hue_d   = s1_colour_q[3:0];
`ifdef COLOUR_EMPHASIS_EN
    s1_emph_d  = bus.emph;
    s2_emph_d  = s1_emph_q;
`endif
  end

  always_comb begin
    lvl   = BLANK_LVL;
    atten = 1'b0;
    case (s2_state_q)
      ST_BURST:  lvl = s2_sel_q ? BURST_HI : BURST_LO;
      ST_ACTIVE: begin
        case (s2_hue_q)
          4'd0:         lvl = lvl_hi(s2_luma_q);
          4'd13:        lvl = lvl_lo(s2_luma_q);
          4'd14, 4'd15: lvl = BLANK_LVL;
          default:      lvl = s2_sel_q ? lvl_hi(s2_luma_q) : lvl_lo(s2_luma_q);
        endcase
`ifdef COLOUR_EMPHASIS_EN
        atten = (s2_emph_q != 3'd0) && (s2_hue_q <= 4'd13);
`endif
      end
      default: lvl = BLANK_LVL;
    endcase
    if (atten) lvl = lvl - (lvl >> 2);
    video_d = align(lvl);
  end

  // ---------------- Registers ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q        <= '0;
      fcw_act_q    <= FCW_DEFAULT;
      fcw_pend_q   <= FCW_DEFAULT;
      fcw_busy_q   <= 1'b0;
      phase_wrap_q <= 1'b0;
      sc_phase_q   <= '0;
      state_q      <= ST_BLANK;
      burst_cnt_q  <= '0;
      s1_colour_q  <= '0;
      s1_state_q   <= ST_BLANK;
      s1_phase_q   <= '0;
      s2_sel_q     <= 1'b0;
      s2_state_q   <= ST_BLANK;
      s2_luma_q    <= '0;
      s2_hue_q     <= '0;
      video_q      <= VIDEO_BLANK;
`ifdef COLOUR_EMPHASIS_EN
      s1_emph_q    <= '0;
      s2_emph_q    <= '0;
`endif
    end else begin
      acc_q        <= acc_d;
      fcw_act_q    <= fcw_act_d;
      fcw_pend_q   <= fcw_pend_d;
      fcw_busy_q   <= fcw_busy_d;
      phase_wrap_q <= phase_wrap_d;
      sc_phase_q   <= sc_phase_d;
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      s1_colour_q  <= s1_colour_d;
      s1_state_q   <= s1_state_d;
      s1_phase_q   <= s1_phase_d;
      s2_sel_q     <= s2_sel_d;
      s2_state_q   <= s2_state_d;
      s2_luma_q    <= s2_luma_d;
      s2_hue_q     <= s2_hue_d;
      video_q      <= video_d;
`ifdef COLOUR_EMPHASIS_EN
      s1_emph_q    <= s1_emph_d;
      s2_emph_q    <= s2_emph_d;
`endif
    end
  end

  assign bus.fcw_busy   = fcw_busy_q;
  assign bus.phase_wrap = phase_wrap_q;
  assign bus.sc_phase   = sc_phase_q;
  assign bus.in_burst   = (state_q == ST_BURST);
  assign bus.video      = video_q;

endmodule

// File: tb/tb_colour_synth_pipe.sv
// ---------------------------------------------------------------------------
// tb_colour_synth_pipe
// Self-checking bench for colour_synth_pipe (BURST_CLKS overridden to 16).
// A cycle-level behavioural model (integer arithmetic, a history queue for
// the colour pipeline) is advanced after every rising edge; each scenario
// task compares DUT outputs against it and against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_colour_synth_pipe;
  localparam int     ACC_W      = 24;
  localparam int     PHASE_W    = 8;
  localparam int     OUT_W      = 8;
  localparam int     BURST_CLKS = 16;
  localparam longint MODULUS    = 64'd1 << ACC_W;
  localparam longint FCW_DEF    = 1201096;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  colour_synth_pipe_if #(.ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus();

  colour_synth_pipe #(
    .ACC_W(ACC_W), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .BURST_CLKS(BURST_CLKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 = blank, 1 = burst, 2 = active
  typedef struct { int colour; int mode; int phase; } rec_t;
  longint m_acc, m_act, m_pend;
  bit     m_busy, m_wrap;
  int     m_phase, m_mode, m_left, m_video;
  rec_t   hist[$];

  function automatic int lo_of(input int l);
    case (l) 0: return 'h1C; 1: return 'h30; 2: return 'h4C; default: return 'h6A; endcase
  endfunction
  function automatic int hi_of(input int l);
    case (l) 0: return 'h4C; 1: return 'h6A; 2: return 'h90; default: return 'hA8; endcase
  endfunction

  function automatic int video_of(input rec_t r);
    int hue, l, p12;
    hue = r.colour % 16;
    l   = r.colour / 16;
    p12 = (r.phase * 12) / 256;
    if (r.mode == 0) return 'h3C;
    if (r.mode == 1) return (((p12 + 8) % 12) < 6) ? 'h50 : 'h28;
    if (hue == 0)  return hi_of(l);
    if (hue == 13) return lo_of(l);
    if (hue >= 14) return 'h3C;
    return (((p12 + hue) % 12) < 6) ? hi_of(l) : lo_of(l);
  endfunction

  task automatic model_reset();
    rec_t blank;
    blank = '{colour: 0, mode: 0, phase: 0};
    m_acc = 0; m_act = FCW_DEF; m_pend = FCW_DEF;
    m_busy = 0; m_wrap = 0; m_phase = 0; m_mode = 0; m_left = 0;
    m_video = 'h3C;
    hist.delete();
    hist.push_back(blank);
    hist.push_back(blank);
  endtask

  task automatic model_step();
    longint s;
    bit     c;
    int     old_phase;
    s = m_acc + m_act;
    c = (s >= MODULUS);
    old_phase = m_phase;
    m_acc   = s % MODULUS;
    m_wrap  = c;
    m_phase = int'(m_acc >> (ACC_W - PHASE_W));
    if (bus.fcw_load) begin
      m_pend = longint'(bus.fcw_in);
      m_busy = 1;
    end else if (c && m_busy) begin
      m_act  = m_pend;
      m_busy = 0;
    end
    if (bus.burst_start) begin
      m_mode = 1;
      m_left = BURST_CLKS;
    end else if (m_mode == 1) begin
      m_left--;
      if (m_left == 0) m_mode = bus.active_en ? 2 : 0;
    end else begin
      m_mode = bus.active_en ? 2 : 0;
    end
    hist.push_back('{colour: int'(bus.colour_num), mode: m_mode, phase: old_phase});
    m_video = video_of(hist.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first_wrap;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    model_reset();
    tests_run++; if (bus.video !== 8'h3C) begin tests_failed++; $display("FAIL reset_video got %h want 3c", bus.video); end
    tests_run++; if (bus.fcw_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.fcw_busy); end
    tests_run++; if (bus.sc_phase !== 8'h00) begin tests_failed++; $display("FAIL reset_phase got %h want 00", bus.sc_phase); end
    tests_run++; if (bus.in_burst !== 1'b0) begin tests_failed++; $display("FAIL reset_in_burst got %b want 0", bus.in_burst); end
    tests_run++; if (bus.phase_wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap got %b want 0", bus.phase_wrap); end
    reset = 1'b1;
    first_wrap = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.phase_wrap === 1'b1 && first_wrap < 0) first_wrap = i;
      tests_run++; if (bus.sc_phase !== 8'(m_phase)) begin tests_failed++; $display("FAIL reset_run_phase cyc=%0d got %h want %h", i, bus.sc_phase, 8'(m_phase)); end
    end
    tests_run++; if (first_wrap != 14) begin tests_failed++; $display("FAIL first_wrap got %0d want 14", first_wrap); end
    $display("[TB] test_reset done");
  endtask

  task automatic test_solid();
    logic [5:0] codes [3];
    logic [7:0] want  [3];
    codes = '{6'h20, 6'h2D, 6'h0F};
    want  = '{8'h90, 8'h4C, 8'h3C};
    bus.active_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.colour_num = codes[k];
      for (int i = 1; i <= 7; i++) begin
        tick();
        tests_run++; if (bus.video !== 8'(m_video)) begin tests_failed++; $display("FAIL solid_model code=%h cyc=%0d got %h want %h", codes[k], i, bus.video, 8'(m_video)); end
        if (i >= 3) begin
          tests_run++; if (bus.video !== want[k]) begin tests_failed++; $display("FAIL solid_const code=%h cyc=%0d got %h want %h", codes[k], i, bus.video, want[k]); end
        end
      end
    end
    $display("[TB] test_solid done");
  endtask

  task automatic test_fcw_switch();
    int switched, prev_phase, steps_ok;
    bus.fcw_in = 24'h200000;
    bus.fcw_load = 1'b1;
    tick();
    bus.fcw_load = 1'b0;
    tests_run++; if (bus.fcw_busy !== 1'b1) begin tests_failed++; $display("FAIL fcw_busy_set got %b want 1", bus.fcw_busy); end
    switched = -1;
    prev_phase = int'(bus.sc_phase);
    steps_ok = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      tests_run++; if (bus.fcw_busy !== m_busy) begin tests_failed++; $display("FAIL fcw_busy cyc=%0d got %b want %b", i, bus.fcw_busy, m_busy); end
      tests_run++; if (bus.sc_phase !== 8'(m_phase)) begin tests_failed++; $display("FAIL fcw_phase cyc=%0d got %h want %h", i, bus.sc_phase, 8'(m_phase)); end
      if (switched < 0 && bus.phase_wrap === 1'b1) begin
        switched = i;
        tests_run++; if (bus.fcw_busy !== 1'b0) begin tests_failed++; $display("FAIL fcw_busy_clear got %b want 0", bus.fcw_busy); end
      end else if (switched > 0) begin
        tests_run++;
        if (((int'(bus.sc_phase) - prev_phase) & 'hFF) != 'h20) begin
          tests_failed++; $display("FAIL fcw_step cyc=%0d got %h want step 20 from %h", i, bus.sc_phase, 8'(prev_phase));
        end else steps_ok++;
      end
      prev_phase = int'(bus.sc_phase);
    end
    tests_run++; if (switched < 0) begin tests_failed++; $display("FAIL fcw_wrap_timeout got none want a wrap within 40 clks"); end
    $display("[TB] test_fcw_switch done, switched at %0d, %0d clean steps", switched, steps_ok);
  endtask

  task automatic test_hue_pattern();
    logic [5:0] codes [2];
    int hi_cnt;
    logic [7:0] prev [8];
    codes = '{6'h21, 6'h27};
    bus.active_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.colour_num = codes[k];
      repeat (3) tick();
      hi_cnt = 0;
      for (int i = 0; i < 16; i++) begin
        tick();
        tests_run++; if (bus.video !== 8'(m_video)) begin tests_failed++; $display("FAIL hue_model code=%h cyc=%0d got %h want %h", codes[k], i, bus.video, 8'(m_video)); end
        if (i < 8) begin
          prev[i] = bus.video;
          if (bus.video === 8'h90) hi_cnt++;
        end else begin
          tests_run++; if (bus.video !== prev[i-8]) begin tests_failed++; $display("FAIL hue_period code=%h cyc=%0d got %h want %h", codes[k], i, bus.video, prev[i-8]); end
        end
      end
      tests_run++; if (hi_cnt != 4) begin tests_failed++; $display("FAIL hue_duty code=%h got %0d want 4", codes[k], hi_cnt); end
    end
    $display("[TB] test_hue_pattern done");
  endtask

  task automatic test_burst();
    int cnt, saw_lo, saw_hi;
    bus.active_en = 1'b0;
    bus.colour_num = 6'h20;
    repeat (4) tick();
    for (int run = 0; run < 2; run++) begin
      cnt = 0; saw_lo = 0; saw_hi = 0;
      bus.burst_start = 1'b1;
      for (int i = 0; i < 40; i++) begin
        tick();
        bus.burst_start = (run == 1 && i == 9) ? 1'b1 : 1'b0;
        if (bus.in_burst === 1'b1) cnt++;
        if (bus.video === 8'h28) saw_lo = 1;
        if (bus.video === 8'h50) saw_hi = 1;
        tests_run++; if (bus.in_burst !== (m_mode == 1)) begin tests_failed++; $display("FAIL burst_flag run=%0d cyc=%0d got %b want %b", run, i, bus.in_burst, (m_mode == 1)); end
        tests_run++; if (bus.video !== 8'(m_video)) begin tests_failed++; $display("FAIL burst_video run=%0d cyc=%0d got %h want %h", run, i, bus.video, 8'(m_video)); end
      end
      tests_run++; if (cnt != (run == 0 ? 16 : 26)) begin tests_failed++; $display("FAIL burst_len run=%0d got %0d want %0d", run, cnt, (run == 0 ? 16 : 26)); end
      tests_run++; if (!(saw_lo && saw_hi)) begin tests_failed++; $display("FAIL burst_toggle run=%0d got lo=%0d hi=%0d want both", run, saw_lo, saw_hi); end
      tests_run++; if (bus.video !== 8'h3C) begin tests_failed++; $display("FAIL burst_end run=%0d got %h want 3c", run, bus.video); end
    end
    $display("[TB] test_burst done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.colour_num  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) bus.active_en = ~bus.active_en;
      bus.burst_start = ($urandom_range(0, 39) == 0);
      bus.fcw_load    = ($urandom_range(0, 24) == 0);
      bus.fcw_in      = 24'($urandom_range(24'h080000, 24'h7FFFFF));
      tick();
      tests_run++;
      if (bus.video !== 8'(m_video) || bus.sc_phase !== 8'(m_phase) || bus.fcw_busy !== m_busy ||
          bus.phase_wrap !== m_wrap || bus.in_burst !== (m_mode == 1)) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got v=%h ph=%h busy=%b wrap=%b burst=%b want v=%h ph=%h busy=%b wrap=%b burst=%b",
                 i, bus.video, bus.sc_phase, bus.fcw_busy, bus.phase_wrap, bus.in_burst,
                 8'(m_video), 8'(m_phase), m_busy, m_wrap, (m_mode == 1));
      end
    end
    bus.burst_start = 1'b0;
    bus.fcw_load    = 1'b0;
    $display("[TB] test_random done");
  endtask

  task automatic test_reset_mid();
    int first_wrap;
    bus.active_en = 1'b0;
    bus.burst_start = 1'b1;
    tick();
    bus.burst_start = 1'b0;
    tick();
    bus.fcw_in = 24'h100000;
    bus.fcw_load = 1'b1;
    tick();
    bus.fcw_load = 1'b0;
    tests_run++; if (bus.in_burst !== 1'b1 || bus.fcw_busy !== 1'b1) begin tests_failed++; $display("FAIL mid_pre got burst=%b busy=%b want 1 1", bus.in_burst, bus.fcw_busy); end
    #1 reset = 1'b0;
    #1;
    model_reset();
    tests_run++; if (bus.in_burst !== 1'b0) begin tests_failed++; $display("FAIL mid_in_burst got %b want 0", bus.in_burst); end
    tests_run++; if (bus.fcw_busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", bus.fcw_busy); end
    tests_run++; if (bus.video !== 8'h3C) begin tests_failed++; $display("FAIL mid_video got %h want 3c", bus.video); end
    tests_run++; if (bus.sc_phase !== 8'h00) begin tests_failed++; $display("FAIL mid_phase got %h want 00", bus.sc_phase); end
    @(negedge clk);
    reset = 1'b1;
    first_wrap = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.phase_wrap === 1'b1 && first_wrap < 0) first_wrap = i;
      tests_run++; if (bus.sc_phase !== 8'(m_phase)) begin tests_failed++; $display("FAIL mid_run_phase cyc=%0d got %h want %h", i, bus.sc_phase, 8'(m_phase)); end
    end
    tests_run++; if (first_wrap != 14) begin tests_failed++; $display("FAIL mid_first_wrap got %0d want 14", first_wrap); end
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    reset           = 1'b0;
    bus.colour_num  = 6'h00;
    bus.active_en   = 1'b0;
    bus.burst_start = 1'b0;
    bus.fcw_in      = '0;
    bus.fcw_load    = 1'b0;
`ifdef COLOUR_EMPHASIS_EN
    bus.emph        = 3'd0;
`endif
    model_reset();
    test_reset();
    test_solid();
    test_fcw_switch();
    test_hue_pattern();
    test_burst();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
